// File: rtl/spiflash_word_reader.sv
// SPI NOR word reader: READ 0x03 (or FAST_READ 0x0B with SPIFLASH_FAST_READ_EN), 32-bit little-endian word.
// Latency: rvalid 128 core_clk edges after accept (144 with SPIFLASH_FAST_READ_EN), ready again 2 edges later.
// Backpressure: none downstream; req is only taken while ready=1, otherwise it is dropped.
module spiflash_word_reader (
    input  logic        core_clk,
    input  logic        core_rstn,
    input  logic        req,
    input  logic [23:0] addr,
    output logic        ready,
    output logic        rvalid,
    output logic [31:0] rdata,
    output logic        flash_csb,
    output logic        flash_clk,
    output logic        flash_io0_do,
    output logic        flash_io0_oeb,
    input  logic        flash_io1_di
);

`ifdef SPIFLASH_FAST_READ_EN
    localparam logic [7:0] CMD_BYTE = 8'h0B;
    localparam logic [6:0] LAST_BIT = 7'd71;
`else
    localparam logic [7:0] CMD_BYTE = 8'h03;
    localparam logic [6:0] LAST_BIT = 7'd63;
`endif

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CMD   = 3'd1;
    localparam logic [2:0] ST_ADDR  = 3'd2;
`ifdef SPIFLASH_FAST_READ_EN
    localparam logic [2:0] ST_DUMMY = 3'd3;
`endif
    localparam logic [2:0] ST_DATA  = 3'd4;
    localparam logic [2:0] ST_GAP   = 3'd5;

    logic [2:0]  state;
    logic [2:0]  state_nxt;
    logic [6:0]  bit_cnt;
    logic [6:0]  bit_nxt;
    logic        phase;
    logic        gap_cnt;
    logic [31:0] tx_sh;
    logic [31:0] rx_sh;
    logic [31:0] rx_nxt;

    assign bit_nxt = bit_cnt + 7'd1;
    assign rx_nxt  = {rx_sh[30:0], flash_io1_di};

    // Phase of the bit that will be driven next
    always_comb begin
        state_nxt = ST_DATA;
        if (bit_nxt < 7'd8)
            state_nxt = ST_CMD;
        else if (bit_nxt < 7'd32)
            state_nxt = ST_ADDR;
`ifdef SPIFLASH_FAST_READ_EN
        else if (bit_nxt < 7'd40)
            state_nxt = ST_DUMMY;
`endif
    end

    always_ff @(posedge core_clk) begin
        if (!core_rstn) begin
            state         <= ST_IDLE;
            bit_cnt       <= '0;
            phase         <= 1'b0;
            gap_cnt       <= 1'b0;
            tx_sh         <= '0;
            rx_sh         <= '0;
            ready         <= 1'b0;
            rvalid        <= 1'b0;
            rdata         <= '0;
            flash_csb     <= 1'b1;
            flash_clk     <= 1'b0;
            flash_io0_do  <= 1'b0;
            flash_io0_oeb <= 1'b1;
        end else begin
            rvalid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    ready <= 1'b1;
                    if (req && ready) begin
                        state         <= ST_CMD;
                        bit_cnt       <= '0;
                        phase         <= 1'b0;
                        ready         <= 1'b0;
                        flash_csb     <= 1'b0;
                        flash_clk     <= 1'b0;
                        flash_io0_do  <= CMD_BYTE[7];
                        flash_io0_oeb <= 1'b0;
                        // Bit 0 goes out now; the rest queue MSB-first with addr[1:0] forced to 00
                        tx_sh         <= {CMD_BYTE[6:0], addr[23:2], addr[1:0] & 2'b00, 1'b0};
                    end
                end
                ST_GAP: begin
                    gap_cnt <= 1'b1;
                    if (gap_cnt) begin
                        state <= ST_IDLE;
                        ready <= 1'b1;
                    end
                end
                default: begin
                    if (!phase) begin
                        flash_clk <= 1'b1;
                        phase     <= 1'b1;
                    end else begin
                        flash_clk <= 1'b0;
                        phase     <= 1'b0;
                        if (state == ST_DATA)
                            rx_sh <= rx_nxt;
                        if (bit_cnt == LAST_BIT) begin
                            state         <= ST_GAP;
                            gap_cnt       <= 1'b0;
                            flash_csb     <= 1'b1;
                            flash_io0_do  <= 1'b0;
                            flash_io0_oeb <= 1'b1;
                            rvalid        <= 1'b1;
                            // First byte received lands in rdata[7:0]
                            rdata         <= {rx_nxt[7:0], rx_nxt[15:8], rx_nxt[23:16], rx_nxt[31:24]};
                        end else begin
                            bit_cnt <= bit_nxt;
                            state   <= state_nxt;
                            if (bit_nxt < 7'd32) begin
                                flash_io0_do  <= tx_sh[31];
                                flash_io0_oeb <= 1'b0;
                                tx_sh         <= {tx_sh[30:0], 1'b0};
                            end else if (state_nxt == ST_DATA) begin
                                flash_io0_do  <= 1'b0;
                                flash_io0_oeb <= 1'b1;
                            end else begin
                                flash_io0_do  <= 1'b0;
                                flash_io0_oeb <= 1'b0;
                            end
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spiflash_word_reader.sv
// Directed bench for spiflash_word_reader with a behavioural SPI flash (byte at A = A[7:0] + 1).
module tb_spiflash_word_reader;

`ifdef SPIFLASH_FAST_READ_EN
    localparam int         PRE     = 40;
    localparam int         LAT     = 144;
    localparam logic [7:0] EXP_CMD = 8'h0B;
`else
    localparam int         PRE     = 32;
    localparam int         LAT     = 128;
    localparam logic [7:0] EXP_CMD = 8'h03;
`endif
    localparam int TOT = PRE + 32;

    logic        core_clk  = 1'b0;
    logic        core_rstn = 1'b0;
    logic        req       = 1'b0;
    logic [23:0] addr      = '0;
    logic        ready;
    logic        rvalid;
    logic [31:0] rdata;
    logic        flash_csb;
    logic        flash_clk;
    logic        flash_io0_do;
    logic        flash_io0_oeb;
    logic        flash_di  = 1'b0;

    int n_err = 0;
    int n_chk = 0;

    always #5 core_clk = ~core_clk;

    spiflash_word_reader dut (
        .core_clk      (core_clk),
        .core_rstn     (core_rstn),
        .req           (req),
        .addr          (addr),
        .ready         (ready),
        .rvalid        (rvalid),
        .rdata         (rdata),
        .flash_csb     (flash_csb),
        .flash_clk     (flash_clk),
        .flash_io0_do  (flash_io0_do),
        .flash_io0_oeb (flash_io0_oeb),
        .flash_io1_di  (flash_di)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Flash model: captures MOSI on rising flash_clk, drives MISO after rising edge for the master's falling-edge sample
    int          rise_cnt   = 0;
    int          last_rises = 0;
    int          pre_err    = 0;
    logic [39:0] mosi_sh    = '0;

    function automatic logic model_bit(input int d);
        logic [23:0] a;
        logic [7:0]  b;
        a = mosi_sh[PRE-9 -: 24] + 24'(d / 8);
        b = a[7:0] + 8'd1;
        return b[7 - (d % 8)];
    endfunction

    always @(posedge flash_clk or posedge flash_csb) begin
        if (flash_csb) begin
            last_rises = rise_cnt;
            rise_cnt   = 0;
        end else begin
            if (rise_cnt < PRE) begin
                mosi_sh = {mosi_sh[38:0], flash_io0_do};
                if (flash_io0_oeb !== 1'b0) pre_err++;
            end else begin
                if (flash_io0_oeb !== 1'b1 || flash_io0_do !== 1'b0) pre_err++;
                if (rise_cnt < TOT) flash_di = model_bit(rise_cnt - PRE);
            end
            rise_cnt++;
        end
    end

    task automatic wait_ready();
        int w;
        w = 0;
        while (ready !== 1'b1 && w < 300) begin
            @(posedge core_clk); #1;
            w++;
        end
        chk("ready_before_req", 32'(ready), 32'd1);
    endtask

    task automatic run_txn(input logic [23:0] a, input logic [23:0] exp_a, input logic [31:0] exp_w,
                           input bit hold, input bit already_req);
        int rv_at;
        int csb_hi;
        if (!already_req) begin
            wait_ready();
            req  = 1'b1;
            addr = a;
        end
        @(posedge core_clk); #1;
        chk("t0_csb", 32'(flash_csb), 32'd0);
        chk("t0_clk", 32'(flash_clk), 32'd0);
        chk("t0_do", 32'(flash_io0_do), 32'(EXP_CMD[7]));
        chk("t0_oeb", 32'(flash_io0_oeb), 32'd0);
        chk("t0_ready", 32'(ready), 32'd0);
        if (!hold) req = 1'b0;
        rv_at  = -1;
        csb_hi = 0;
        for (int k = 1; k <= LAT + 4 && rv_at < 0; k++) begin
            @(posedge core_clk); #1;
            if (rvalid === 1'b1) rv_at = k;
            else if (flash_csb !== 1'b0) csb_hi++;
        end
        chk("rvalid_latency", rv_at, LAT);
        chk("rdata", rdata, exp_w);
        chk("csb_low_during_txn", csb_hi, 0);
        chk("end_csb", 32'(flash_csb), 32'd1);
        chk("end_clk", 32'(flash_clk), 32'd0);
        chk("sclk_rises", last_rises, TOT);
        chk("mosi_cmd", 32'(mosi_sh[PRE-1 -: 8]), 32'(EXP_CMD));
        chk("mosi_addr", 32'(mosi_sh[PRE-9 -: 24]), 32'(exp_a));
`ifdef SPIFLASH_FAST_READ_EN
        chk("mosi_dummy", 32'(mosi_sh[7:0]), 32'd0);
`endif
        chk("io0_oeb_shape", pre_err, 0);
        @(posedge core_clk); #1;
        chk("gap1_rvalid", 32'(rvalid), 32'd0);
        chk("gap1_ready", 32'(ready), 32'd0);
        chk("gap1_csb", 32'(flash_csb), 32'd1);
        @(posedge core_clk); #1;
        chk("gap2_ready", 32'(ready), 32'd1);
        chk("rdata_hold", rdata, exp_w);
    endtask

    initial begin
        int rv_cnt;
        core_rstn = 1'b0;
        repeat (3) @(posedge core_clk);
        #1;
        chk("rst_csb", 32'(flash_csb), 32'd1);
        chk("rst_clk", 32'(flash_clk), 32'd0);
        chk("rst_do", 32'(flash_io0_do), 32'd0);
        chk("rst_oeb", 32'(flash_io0_oeb), 32'd1);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_ready", 32'(ready), 32'd0);
        core_rstn = 1'b1;
        @(posedge core_clk); #1;
        chk("ready_first_edge", 32'(ready), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge core_clk); #1;
            chk("idle_csb", 32'(flash_csb), 32'd1);
            chk("idle_rvalid", 32'(rvalid), 32'd0);
        end

        run_txn(24'h000100, 24'h000100, 32'h04030201, 1'b0, 1'b0);
        run_txn(24'h000103, 24'h000100, 32'h04030201, 1'b0, 1'b0);
        run_txn(24'h12345C, 24'h12345C, 32'h605F5E5D, 1'b0, 1'b0);

        // req held high: second accept follows directly on the cycle ready returns
        run_txn(24'h000200, 24'h000200, 32'h04030201, 1'b1, 1'b0);
        run_txn(24'h000200, 24'h000200, 32'h04030201, 1'b0, 1'b1);

        // Reset at T0+40 aborts the transfer
        wait_ready();
        req  = 1'b1;
        addr = 24'h000100;
        @(posedge core_clk); #1;
        chk("abort_t0_csb", 32'(flash_csb), 32'd0);
        req = 1'b0;
        repeat (39) @(posedge core_clk);
        #1;
        core_rstn = 1'b0;
        req       = 1'b1;
        @(posedge core_clk); #1;
        chk("abort_csb", 32'(flash_csb), 32'd1);
        chk("abort_rvalid", 32'(rvalid), 32'd0);
        chk("abort_rdata", rdata, 32'd0);
        chk("abort_ready", 32'(ready), 32'd0);
        chk("abort_oeb", 32'(flash_io0_oeb), 32'd1);
        @(posedge core_clk); #1;
        chk("rst_over_req_csb", 32'(flash_csb), 32'd1);
        chk("rst_over_req_ready", 32'(ready), 32'd0);
        core_rstn = 1'b1;
        req       = 1'b0;
        @(posedge core_clk); #1;
        chk("abort_ready_release", 32'(ready), 32'd1);
        rv_cnt = 0;
        for (int i = 0; i < 150; i++) begin
            @(posedge core_clk); #1;
            if (rvalid === 1'b1 || flash_csb !== 1'b1) rv_cnt++;
        end
        chk("abort_no_activity", rv_cnt, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
